// File: rtl/lse_mult_pipe.sv
// Log-domain (LSE) multiplier: a saturating packed-lane adder with a two-stage, backpressured pipeline.
// Lane layout per beat is chosen by pe_mode: 1 x WIDTH, WIDTH/LANE_W x LANE_W or WIDTH/(2*LANE_W) x 2*LANE_W.

module lse_lane_sat #(
    parameter int L = 6
) (
    input  logic [L:0]   sum,
    input  logic         ninf,
    output logic [L-1:0] lane_res,
    output logic         lane_sat
);
    localparam logic [L-1:0] NEG_INF = {1'b1, {(L-1){1'b0}}};
    localparam logic [L-1:0] MAX_POS = ~NEG_INF;
    localparam logic [L-1:0] MIN_SAT = NEG_INF | {{(L-1){1'b0}}, 1'b1};

    logic pos_ovf;
    logic neg_ovf;

    // The most negative code is reserved for NEG_INF, so a sum landing on it also clamps.
    assign pos_ovf = !sum[L] && sum[L-1];
    assign neg_ovf = sum[L] && (!sum[L-1] || (sum[L-2:0] == '0));

    always_comb begin
        lane_res = sum[L-1:0];
        lane_sat = 1'b0;
        if (ninf) begin
            lane_res = NEG_INF;
        end else if (pos_ovf) begin
            lane_res = MAX_POS;
            lane_sat = 1'b1;
        end else if (neg_ovf) begin
            lane_res = MIN_SAT;
            lane_sat = 1'b1;
        end
    end
endmodule

module lse_mult_pipe #(
    parameter int WIDTH  = 24,
    parameter int LANE_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic [1:0]       pe_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             out_sat,
    input  logic             clr_count,
    output logic [15:0]      sat_count
);
    localparam int DW = 2 * LANE_W;
    localparam int NN = WIDTH / LANE_W;
    localparam int ND = WIDTH / DW;

    localparam logic [WIDTH-1:0]  NINF_W = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [LANE_W-1:0] NINF_N = {1'b1, {(LANE_W-1){1'b0}}};
    localparam logic [DW-1:0]     NINF_D = {1'b1, {(DW-1){1'b0}}};

    if ((WIDTH % DW) != 0) begin : g_bad_width
        $error("lse_mult_pipe: WIDTH must be a multiple of 2*LANE_W");
    end

    logic                     en;
    logic                     accept;
    logic [WIDTH:0]           sum_w_d, s1_sum_w;
    logic                     ninf_w_d, s1_ninf_w;
    logic [NN*(LANE_W+1)-1:0] sum_n_d, s1_sum_n;
    logic [NN-1:0]            ninf_n_d, s1_ninf_n;
    logic [ND*(DW+1)-1:0]     sum_d_d, s1_sum_d;
    logic [ND-1:0]            ninf_d_d, s1_ninf_d;
    logic                     s1_valid;
    logic [1:0]               s1_mode;
    logic [WIDTH-1:0]         res_w, res_n, res_d, res_sel;
    logic                     sat_w, sat_sel;
    logic [NN-1:0]            sat_n;
    logic [ND-1:0]            sat_d;

    assign en       = !out_valid || out_ready;
    assign in_ready = en && !rst;
    assign accept   = in_valid && in_ready;

    // All three lane layouts are summed in parallel; S2 picks the one matching the captured mode.
    assign sum_w_d  = {operand_a[WIDTH-1], operand_a} + {operand_b[WIDTH-1], operand_b};
    assign ninf_w_d = (operand_a == NINF_W) || (operand_b == NINF_W);

    for (genvar i = 0; i < NN; i++) begin : g_nar_add
        logic [LANE_W-1:0] a_l, b_l;
        assign a_l = operand_a[i*LANE_W +: LANE_W];
        assign b_l = operand_b[i*LANE_W +: LANE_W];
        assign sum_n_d[i*(LANE_W+1) +: LANE_W+1] = {a_l[LANE_W-1], a_l} + {b_l[LANE_W-1], b_l};
        assign ninf_n_d[i] = (a_l == NINF_N) || (b_l == NINF_N);
    end

    for (genvar i = 0; i < ND; i++) begin : g_dbl_add
        logic [DW-1:0] a_l, b_l;
        assign a_l = operand_a[i*DW +: DW];
        assign b_l = operand_b[i*DW +: DW];
        assign sum_d_d[i*(DW+1) +: DW+1] = {a_l[DW-1], a_l} + {b_l[DW-1], b_l};
        assign ninf_d_d[i] = (a_l == NINF_D) || (b_l == NINF_D);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_mode   <= 2'b00;
            s1_sum_w  <= '0;
            s1_ninf_w <= 1'b0;
            s1_sum_n  <= '0;
            s1_ninf_n <= '0;
            s1_sum_d  <= '0;
            s1_ninf_d <= '0;
        end else if (en) begin
            s1_valid <= accept;
            if (accept) begin
                s1_mode   <= pe_mode;
                s1_sum_w  <= sum_w_d;
                s1_ninf_w <= ninf_w_d;
                s1_sum_n  <= sum_n_d;
                s1_ninf_n <= ninf_n_d;
                s1_sum_d  <= sum_d_d;
                s1_ninf_d <= ninf_d_d;
            end
        end
    end

    lse_lane_sat #(.L(WIDTH)) u_sat_w (
        .sum      (s1_sum_w),
        .ninf     (s1_ninf_w),
        .lane_res (res_w),
        .lane_sat (sat_w)
    );

    for (genvar i = 0; i < NN; i++) begin : g_nar_sat
        lse_lane_sat #(.L(LANE_W)) u_sat (
            .sum      (s1_sum_n[i*(LANE_W+1) +: LANE_W+1]),
            .ninf     (s1_ninf_n[i]),
            .lane_res (res_n[i*LANE_W +: LANE_W]),
            .lane_sat (sat_n[i])
        );
    end

    for (genvar i = 0; i < ND; i++) begin : g_dbl_sat
        lse_lane_sat #(.L(DW)) u_sat (
            .sum      (s1_sum_d[i*(DW+1) +: DW+1]),
            .ninf     (s1_ninf_d[i]),
            .lane_res (res_d[i*DW +: DW]),
            .lane_sat (sat_d[i])
        );
    end

    always_comb begin
        res_sel = res_w;
        sat_sel = sat_w;
        case (s1_mode)
            2'b01: begin
                res_sel = res_n;
                sat_sel = |sat_n;
            end
            2'b10: begin
                res_sel = res_d;
                sat_sel = |sat_d;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            result    <= '0;
            out_sat   <= 1'b0;
        end else if (en) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                result  <= res_sel;
                out_sat <= sat_sel;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr_count) begin
            sat_count <= '0;
        end else if (out_valid && out_ready && out_sat && (sat_count != 16'hFFFF)) begin
            sat_count <= sat_count + 16'd1;
        end
    end
endmodule

// File: tb/tb_lse_mult_pipe.sv
// Self-checking bench for lse_mult_pipe: vector table, scoreboard of expected beats, and
// hand-written sequences for latency, backpressure, counter saturation/clear and mid-stream reset.

module tb_lse_mult_pipe;
    localparam int WIDTH  = 24;
    localparam int LANE_W = 6;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic [1:0]       pe_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             out_sat;
    logic             clr_count;
    logic [15:0]      sat_count;

    lse_mult_pipe #(.WIDTH(WIDTH), .LANE_W(LANE_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .pe_mode   (pe_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .out_sat   (out_sat),
        .clr_count (clr_count),
        .sat_count (sat_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [1:0]       mode;
        logic [WIDTH-1:0] exp_res;
        logic             exp_sat;
    } vec_t;

    typedef struct {
        logic [WIDTH-1:0] res;
        logic             sat;
    } exp_t;

    exp_t        sb[$];
    exp_t        pend;
    int          checks = 0;
    int          failures = 0;
    logic [15:0] exp_cnt = 16'h0;
    bit          accepted_last = 1'b0;
    bit          rand_ready = 1'b0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic failTimeout(input string name);
        checks++;
        failures++;
        $display("[TB] FAIL %s: got timeout, expected completion within bound", name);
    endtask

    // Reference: signed lanes of width l, NEG_INF absorbing, clamp to +/-(2^(l-1)-1).
    function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                             input logic [1:0] mode);
        int               l;
        longint           half, mask, av, bv, s, r;
        logic [WIDTH-1:0] res;
        logic             sat;
        l    = (mode == 2'b01) ? LANE_W : (mode == 2'b10) ? 2 * LANE_W : WIDTH;
        half = longint'(1) << (l - 1);
        mask = (longint'(1) << l) - 1;
        res  = '0;
        sat  = 1'b0;
        for (int i = 0; i < WIDTH / l; i++) begin
            av = (longint'(a) >> (i * l)) & mask;
            bv = (longint'(b) >> (i * l)) & mask;
            if (av >= half) av = av - 2 * half;
            if (bv >= half) bv = bv - 2 * half;
            if (av == -half || bv == -half) begin
                r = -half;
            end else begin
                s = av + bv;
                if (s > half - 1) begin
                    r = half - 1;
                    sat = 1'b1;
                end else if (s <= -half) begin
                    r = -(half - 1);
                    sat = 1'b1;
                end else begin
                    r = s;
                end
            end
            res = res | WIDTH'((r & mask) << (i * l));
        end
        return {sat, res};
    endfunction

    // One clock: monitor/score at the falling edge, then step past the rising edge.
    task automatic tick();
        exp_t head;
        bit   have_head;
        @(negedge clk);
        have_head = 1'b0;
        if (rst) begin
            sb.delete();
            exp_cnt = 16'h0;
            accepted_last = 1'b0;
        end else begin
            checkOutput("sat_count", 64'(sat_count), 64'(exp_cnt));
            if (out_valid) begin
                if (sb.size() == 0) begin
                    checkOutput("stale_beat", 64'(out_valid), 64'(0));
                end else begin
                    head = sb[0];
                    have_head = 1'b1;
                    checkOutput("result", 64'(result), 64'(head.res));
                    checkOutput("out_sat", 64'(out_sat), 64'(head.sat));
                    if (out_ready) void'(sb.pop_front());
                end
            end
            if (clr_count) exp_cnt = 16'h0;
            else if (out_valid && out_ready && have_head && head.sat && exp_cnt != 16'hFFFF)
                exp_cnt = exp_cnt + 16'd1;
            accepted_last = in_valid && in_ready;
            if (accepted_last) sb.push_back(pend);
        end
        @(posedge clk);
        #1;
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic driveBeat(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [1:0] mode,
                             input logic [WIDTH-1:0] er, input logic es);
        operand_a = a;
        operand_b = b;
        pe_mode   = mode;
        pend.res  = er;
        pend.sat  = es;
        in_valid  = 1'b1;
    endtask

    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [1:0] mode,
                                 input logic [WIDTH-1:0] er, input logic es);
        int n;
        n = 0;
        driveBeat(a, b, mode, er, es);
        do begin
            tick();
            n++;
        end while (!accepted_last && n < 200);
        if (!accepted_last) failTimeout("accept_timeout");
    endtask

    task automatic drain();
        int n;
        n = 0;
        in_valid   = 1'b0;
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        while ((sb.size() != 0 || out_valid) && n < 100) begin
            tick();
            n++;
        end
        checkOutput("drain_empty", 64'(sb.size()), 64'(0));
    endtask

    initial begin
        vec_t             vecs[12];
        logic [WIDTH-1:0] bp_a[4];
        logic [WIDTH-1:0] bp_b[4];
        logic [1:0]       bp_m[4];
        logic [WIDTH:0]   m;
        logic [WIDTH-1:0] ra, rb;
        logic [1:0]       rm;
        int               k;

        vecs[0]  = '{24'h100000, 24'h200000, 2'b00, 24'h300000, 1'b0};
        vecs[1]  = '{24'hFFFFFF, 24'h000001, 2'b00, 24'h000000, 1'b0};
        vecs[2]  = '{24'h7FFFFF, 24'h000001, 2'b00, 24'h7FFFFF, 1'b1};
        vecs[3]  = '{24'h800000, 24'h123456, 2'b00, 24'h800000, 1'b0};
        vecs[4]  = '{24'h0420C4, 24'h0420C4, 2'b01, 24'h084188, 1'b0};
        vecs[5]  = '{24'h02181F, 24'h03F141, 2'b01, 24'h02181F, 1'b1};
        vecs[6]  = '{24'h7FFFFF, 24'h000001, 2'b11, 24'h7FFFFF, 1'b1};
        vecs[7]  = '{24'h7FF001, 24'h001001, 2'b10, 24'h7FF002, 1'b1};
        vecs[8]  = '{24'h000FFF, 24'h000001, 2'b10, 24'h000000, 1'b0};
        vecs[9]  = '{24'h00003F, 24'h000001, 2'b01, 24'h000000, 1'b0};
        vecs[10] = '{24'h800001, 24'hFFFFFF, 2'b00, 24'h800001, 1'b1};
        vecs[11] = '{24'h800000, 24'h7FF7FF, 2'b10, 24'h8007FF, 1'b0};

        bp_a = '{24'h0420C4, 24'h7FF001, 24'h123456, 24'h02181F};
        bp_b = '{24'h010101, 24'h001001, 24'h111111, 24'h03F141};
        bp_m = '{2'b01, 2'b10, 2'b00, 2'b01};

        rst        = 1'b1;
        in_valid   = 1'b0;
        operand_a  = '0;
        operand_b  = '0;
        pe_mode    = 2'b00;
        out_ready  = 1'b1;
        clr_count  = 1'b0;
        pend.res   = '0;
        pend.sat   = 1'b0;

        repeat (3) tick();
        checkOutput("reset_in_ready", 64'(in_ready), 64'(0));
        checkOutput("reset_out_valid", 64'(out_valid), 64'(0));
        checkOutput("reset_result", 64'(result), 64'(0));
        checkOutput("reset_out_sat", 64'(out_sat), 64'(0));
        checkOutput("reset_sat_count", 64'(sat_count), 64'(0));
        rst = 1'b0;
        #1;
        checkOutput("post_reset_in_ready", 64'(in_ready), 64'(1));

        $display("[TB] table vectors");
        foreach (vecs[i]) applyStimulus(vecs[i].a, vecs[i].b, vecs[i].mode, vecs[i].exp_res, vecs[i].exp_sat);
        drain();

        $display("[TB] latency");
        applyStimulus(24'h000005, 24'h000003, 2'b00, 24'h000008, 1'b0);
        in_valid = 1'b0;
        checkOutput("latency_n1", 64'(out_valid), 64'(0));
        tick();
        checkOutput("latency_n2", 64'(out_valid), 64'(1));
        drain();

        $display("[TB] backpressure");
        k = 0;
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            m = model(bp_a[k], bp_b[k], bp_m[k]);
            driveBeat(bp_a[k], bp_b[k], bp_m[k], m[WIDTH-1:0], m[WIDTH]);
            tick();
            if (accepted_last) k++;
        end
        checkOutput("bp_in_ready", 64'(in_ready), 64'(0));
        checkOutput("bp_accepted", 64'(k), 64'(2));
        out_ready = 1'b1;
        while (k < 4) begin
            m = model(bp_a[k], bp_b[k], bp_m[k]);
            applyStimulus(bp_a[k], bp_b[k], bp_m[k], m[WIDTH-1:0], m[WIDTH]);
            k++;
        end
        drain();

        $display("[TB] random stream");
        rand_ready = 1'b1;
        for (int i = 0; i < 60; i++) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            rm = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 5) == 0) begin
                if (rm == 2'b01)      ra = (ra & ~24'h00003F) | 24'h000020;
                else if (rm == 2'b10) ra = (ra & ~24'h000FFF) | 24'h000800;
                else                  ra = 24'h800000;
            end
            m = model(ra, rb, rm);
            applyStimulus(ra, rb, rm, m[WIDTH-1:0], m[WIDTH]);
        end
        drain();

        $display("[TB] counter saturation and clear");
        out_ready = 1'b1;
        driveBeat(24'h7FFFFF, 24'h000001, 2'b00, 24'h7FFFFF, 1'b1);
        repeat (65540) tick();
        checkOutput("cnt_hold", 64'(sat_count), 64'(16'hFFFF));
        clr_count = 1'b1;
        tick();
        clr_count = 1'b0;
        checkOutput("clr_priority", 64'(sat_count), 64'(0));
        tick();
        checkOutput("pre_rst_count", 64'(sat_count), 64'(1));

        $display("[TB] reset mid-stream");
        rst = 1'b1;
        in_valid = 1'b0;
        tick();
        checkOutput("rst_out_valid", 64'(out_valid), 64'(0));
        checkOutput("rst_sat_count", 64'(sat_count), 64'(0));
        checkOutput("rst_in_ready", 64'(in_ready), 64'(0));
        rst = 1'b0;
        #1;
        checkOutput("rst_release_in_ready", 64'(in_ready), 64'(1));
        for (int c = 0; c < 5; c++) begin
            tick();
            checkOutput("no_stale", 64'(out_valid), 64'(0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
